// File: rtl/ge_select_pkg.sv
// Shared types and constants for the sequential Ed25519 precomputed-point select:
// FSM states, field-element and ge_precomp types, the neutral element and the table depth.
package ge_select_pkg;

   localparam int DEF_NLIMB = 10;
   localparam int DEF_LIMBW = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_NEG,
      ST_DONE
   } state_t;

   // Limb 0 sits in the least significant LIMBW bits.
   typedef logic signed [DEF_NLIMB-1:0][DEF_LIMBW-1:0] fe_t;

   typedef struct packed {
      fe_t yplusx;
      fe_t yminusx;
      fe_t xy2d;
   } ge_precomp_t;

   localparam ge_precomp_t GE_NEUTRAL = '{yplusx: fe_t'(1), yminusx: fe_t'(1), xy2d: '0};

   // Number of table entries per row for a WIN-bit signed window.
   function automatic int ge_depth(input int win);
      return 1 << (win - 1);
   endfunction

endpackage

// File: rtl/ge_select_seq_fe_neg_p.sv
// Limb-wise negation of a field element: every signed limb is negated modulo 2^LIMBW
// on its own, with no carry between limbs.
module fe_neg_p #(
   parameter int NLIMB = 10,
   parameter int LIMBW = 32
) (
   input  logic [NLIMB*LIMBW-1:0] a,
   output logic [NLIMB*LIMBW-1:0] y
);

   for (genvar i = 0; i < NLIMB; i++) begin : g_limb
      assign y[i*LIMBW +: LIMBW] = LIMBW'(0) - a[i*LIMBW +: LIMBW];
   end

endmodule

// File: rtl/ge_select_seq.sv
// Constant-time sequential select of a precomputed point from an external synchronous ROM.
// Build option GE_SELECT_SCRUB_EN clears results and latched secrets on the output handshake.
module ge_select_seq
   import ge_select_pkg::*;
#(
   parameter int WIN   = 4,
   parameter int NPOS  = 32,
   parameter int NLIMB = 10,
   parameter int LIMBW = 32,
   localparam int PW   = $clog2(NPOS),
   localparam int FEW  = NLIMB * LIMBW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PW-1:0]         in_pos,
   input  logic signed [WIN:0]   in_b,
   output logic                  rom_en,
   output logic [PW-1:0]         rom_pos,
   output logic [WIN-2:0]        rom_j,
   input  logic [FEW-1:0]        rom_yplusx,
   input  logic [FEW-1:0]        rom_yminusx,
   input  logic [FEW-1:0]        rom_xy2d,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FEW-1:0]        out_yplusx,
   output logic [FEW-1:0]        out_yminusx,
   output logic [FEW-1:0]        out_xy2d
);

   localparam int D = ge_depth(WIN);
   localparam logic [WIN-1:0] D_C = WIN'(D);

   typedef struct packed {
      logic [FEW-1:0] yplusx;
      logic [FEW-1:0] yminusx;
      logic [FEW-1:0] xy2d;
   } pt_t;

   localparam pt_t NEUTRAL = '{yplusx: FEW'(1), yminusx: FEW'(1), xy2d: '0};

   state_t          state_q, state_d;
   logic [PW-1:0]   pos_q;
   logic            bneg_q;
   logic [WIN:0]    babs_q;
   logic [WIN-1:0]  cnt_q;
   pt_t             acc_q, out_q;

   logic            bneg_c;
   logic [WIN:0]    babs_c;
   logic            hit;
   pt_t             rom_pt, hit_mask, merged, cand;
   logic [FEW-1:0]  neg_xy2d;

   // |b| without a branch: subtract 2b only when the sign bit is set.
   assign bneg_c = in_b[WIN];
   assign babs_c = in_b - (({(WIN+1){bneg_c}} & in_b) << 1);

   // Entry c-1 is on the ROM bus during scan cycle c; digits outside [1, D] never hit.
   assign hit      = (state_q == ST_SCAN) && (cnt_q != '0) && (babs_q == {1'b0, cnt_q});
   assign rom_pt   = {rom_yplusx, rom_yminusx, rom_xy2d};
   assign hit_mask = {(3*FEW){hit}};
   assign merged   = (rom_pt & hit_mask) | (acc_q & ~hit_mask);

   fe_neg_p #(
      .NLIMB (NLIMB),
      .LIMBW (LIMBW)
   ) u_fe_neg (
      .a (acc_q.xy2d),
      .y (neg_xy2d)
   );

   assign cand = '{yplusx: acc_q.yminusx, yminusx: acc_q.yplusx, xy2d: neg_xy2d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rom_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_SCAN;
         end
         ST_SCAN: begin
            rom_en = (cnt_q != D_C);
            if (cnt_q == D_C) state_d = ST_NEG;
         end
         ST_NEG: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the wide accumulator and result registers are reset too, so an aborted
   // scan never leaves a partially selected secret on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q  <= '0;
         bneg_q <= 1'b0;
         babs_q <= '0;
         cnt_q  <= '0;
         acc_q  <= '0;
         out_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  pos_q  <= in_pos;
                  bneg_q <= bneg_c;
                  babs_q <= babs_c;
                  acc_q  <= NEUTRAL;
                  cnt_q  <= '0;
               end
            end
            ST_SCAN: begin
               acc_q <= merged;
               cnt_q <= (cnt_q == D_C) ? '0 : cnt_q + WIN'(1);
            end
            ST_NEG: begin
               out_q <= bneg_q ? cand : acc_q;
            end
            ST_DONE: begin
`ifdef GE_SELECT_SCRUB_EN
               if (out_ready) begin
                  out_q  <= '0;
                  acc_q  <= '0;
                  pos_q  <= '0;
                  bneg_q <= 1'b0;
                  babs_q <= '0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign rom_pos     = pos_q;
   assign rom_j       = cnt_q[WIN-2:0];
   assign out_yplusx  = out_q.yplusx;
   assign out_yminusx = out_q.yminusx;
   assign out_xy2d    = out_q.xy2d;

endmodule

// File: tb/tb_ge_select_seq.sv
// Self-checking bench for ge_select_seq: a behavioural ROM and select model feed one
// per-cycle compare process; directed digits cover matching, negation, out-of-range and stalls.
module tb_ge_select_seq;
   import ge_select_pkg::*;

   localparam int WIN   = 4;
   localparam int NPOS  = 32;
   localparam int NLIMB = DEF_NLIMB;
   localparam int LIMBW = DEF_LIMBW;
   localparam int PW    = $clog2(NPOS);
   localparam int FEW   = NLIMB * LIMBW;
   localparam int BW    = WIN + 1;
   localparam int DEPTH = 8;
   localparam int LAT   = 11;

   logic                 clk, rst_n;
   logic                 in_valid, in_ready, rom_en, out_valid, out_ready;
   logic [PW-1:0]        in_pos, rom_pos;
   logic signed [BW-1:0] in_b;
   logic [WIN-2:0]       rom_j;
   logic [FEW-1:0]       rom_yplusx, rom_yminusx, rom_xy2d;
   logic [FEW-1:0]       out_yplusx, out_yminusx, out_xy2d;

   int total = 0;
   int bad   = 0;

   ge_select_seq #(
      .WIN   (WIN),
      .NPOS  (NPOS),
      .NLIMB (NLIMB),
      .LIMBW (LIMBW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pos      (in_pos),
      .in_b        (in_b),
      .rom_en      (rom_en),
      .rom_pos     (rom_pos),
      .rom_j       (rom_j),
      .rom_yplusx  (rom_yplusx),
      .rom_yminusx (rom_yminusx),
      .rom_xy2d    (rom_xy2d),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_yplusx  (out_yplusx),
      .out_yminusx (out_yminusx),
      .out_xy2d    (out_xy2d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [FEW-1:0] act, input logic [FEW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Table contents: each limb encodes {pos, entry, field, limb}; odd limbs are negative.
   function automatic fe_t rom_fe(input int pos, input int j, input int f);
      fe_t r;
      for (int i = 0; i < NLIMB; i++) begin
         r[i] = {8'(pos), 8'(j), 8'(f), 8'(i)};
         if (i % 2 == 1) r[i][31] = 1'b1;
      end
      return r;
   endfunction

   function automatic ge_precomp_t model(input int pos, input int b);
      ge_precomp_t r;
      fe_t         t;
      longint      v;
      int          mag;
      mag = (b < 0) ? -b : b;
      if (mag >= 1 && mag <= DEPTH) begin
         r.yplusx  = rom_fe(pos, mag - 1, 0);
         r.yminusx = rom_fe(pos, mag - 1, 1);
         r.xy2d    = rom_fe(pos, mag - 1, 2);
      end else begin
         r = GE_NEUTRAL;
      end
      if (b < 0) begin
         t         = r.yplusx;
         r.yplusx  = r.yminusx;
         r.yminusx = t;
         for (int i = 0; i < NLIMB; i++) begin
            v         = 64'h1_0000_0000 - longint'(r.xy2d[i]);
            r.xy2d[i] = v[31:0];
         end
      end
      return r;
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clk) begin
      if (rom_en) begin
         rom_yplusx  <= rom_fe(int'(rom_pos), int'(rom_j), 0);
         rom_yminusx <= rom_fe(int'(rom_pos), int'(rom_j), 1);
         rom_xy2d    <= rom_fe(int'(rom_pos), int'(rom_j), 2);
      end
   end

   ge_precomp_t   exp_q, last_q;
   logic [PW-1:0] exp_pos;
   bit            busy    = 1'b0;
   bit            post_hs = 1'b0;
   int            cyc     = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_in_ready", in_ready, 1);
         check("rst_out_valid", out_valid, 0);
         check("rst_rom_en", rom_en, 0);
         check("rst_rom_j", rom_j, 0);
         check("rst_rom_pos", rom_pos, 0);
         check("rst_out_yplusx", out_yplusx, 0);
         check("rst_out_yminusx", out_yminusx, 0);
         check("rst_out_xy2d", out_xy2d, 0);
         busy    = 1'b0;
         post_hs = 1'b0;
      end else begin
         if (post_hs) begin
`ifdef GE_SELECT_SCRUB_EN
            check("scrub_yplusx", out_yplusx, 0);
            check("scrub_yminusx", out_yminusx, 0);
            check("scrub_xy2d", out_xy2d, 0);
`else
            check("hold_yplusx", out_yplusx, last_q.yplusx);
            check("hold_yminusx", out_yminusx, last_q.yminusx);
            check("hold_xy2d", out_xy2d, last_q.xy2d);
`endif
            post_hs = 1'b0;
         end
         if (busy) begin
            cyc++;
            check("busy_in_ready", in_ready, 0);
            check("out_valid_timing", out_valid, cyc >= LAT);
            check("rom_en_timing", rom_en, cyc >= 1 && cyc <= DEPTH);
            if (rom_en) begin
               check("rom_j", rom_j, FEW'(cyc - 1));
               check("rom_pos", rom_pos, exp_pos);
            end
            if (out_valid) begin
               check("out_yplusx", out_yplusx, exp_q.yplusx);
               check("out_yminusx", out_yminusx, exp_q.yminusx);
               check("out_xy2d", out_xy2d, exp_q.xy2d);
               if (out_ready) begin
                  busy    = 1'b0;
                  post_hs = 1'b1;
                  last_q  = exp_q;
               end
            end
         end else begin
            check("idle_in_ready", in_ready, 1);
            check("idle_out_valid", out_valid, 0);
            check("idle_rom_en", rom_en, 0);
            if (in_valid) begin
               exp_q   = model(int'(in_pos), int'(in_b));
               exp_pos = in_pos;
               busy    = 1'b1;
               cyc     = 0;
            end
         end
      end
   end

   task automatic req(input int pos, input int b, input int hold, output ge_precomp_t got);
      int n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_pos   = PW'(pos);
      in_b     = BW'(b);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) check("result_timeout", 0, 1);
      got.yplusx  = out_yplusx;
      got.yminusx = out_yminusx;
      got.xy2d    = out_xy2d;
      // Requests offered while the result waits must be ignored.
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_pos   = PW'(pos + 1);
         in_b     = BW'(b + 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   ge_precomp_t got;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_pos    = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      req(5, 0, 0, got);
      check("lit_b0_yplusx", got.yplusx, FEW'(1));
      check("lit_b0_xy2d", got.xy2d, 0);

      req(5, 3, 0, got);
      check("lit_p3_yplusx_l0", got.yplusx[0], 32'h0502_0000);
      req(5, 8, 0, got);
      check("lit_p8_yplusx_l0", got.yplusx[0], 32'h0507_0000);

      req(5, -3, 0, got);
      check("lit_m3_yplusx_l0", got.yplusx[0], 32'h0502_0100);
      check("lit_m3_xy2d_l1", got.xy2d[1], 32'h7AFD_FDFF);
      req(5, -8, 0, got);
      check("lit_m8_xy2d_l1", got.xy2d[1], 32'h7AF8_FDFF);

      req(5, 9, 0, got);
      check("lit_9_yminusx", got.yminusx, FEW'(1));
      req(5, -16, 0, got);
      check("lit_m16_yplusx", got.yplusx, FEW'(1));
      check("lit_m16_xy2d", got.xy2d, 0);

      for (int b = -16; b <= 15; b++) begin
         req(((b + 16) * 7) % NPOS, b, 0, got);
      end

      req(12, 5, 5, got);
      req(12, -7, 5, got);

      // Abort in the middle of a scan, then confirm the next request is clean.
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_pos   = PW'(9);
      in_b     = BW'(4);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      req(9, -6, 0, got);
      req(9, 4, 0, got);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
